// File: rtl/uart_tx_sequencer_if.sv
// Transmit-source handshake between a word producer and the UART frame sequencer.
interface uart_tx_sequencer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_sequencer.sv
// UART frame sequencer: start, LSB-first data, optional parity, stop bits, one bit per
// timer tick, with one timer_start pulse on accept and one timer_stop pulse on frame end.
module uart_tx_sequencer #(
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_EN  = 1'b0,
  parameter bit PARITY_ODD = 1'b0,
  parameter int STOP_BITS  = 1
) (
  input  logic                clk,
  input  logic                rst,
  uart_tx_sequencer_if.slave  bus,
  input  logic                tick,
  output logic                tx,
  output logic                busy,
  output logic                timer_start,
  output logic                timer_stop,
  output logic                frame_done
);
  localparam int CW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;
  logic                 stop_q, stop_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

  // Next-state values are the registered outputs for the following cycle, so each
  // output shows the new bit right after the tick edge with no extra latency.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (bus.tx_valid && ready_q) begin
          shift_d = bus.tx_data;
          par_d   = (^bus.tx_data) ^ PARITY_ODD;
          cnt_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          start_d = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
          cnt_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (cnt_q == CW'(DATA_BITS - 1)) begin
            cnt_d = '0;
            if (PARITY_EN) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
          cnt_d   = '0;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (tick) begin
          if (cnt_q == CW'(STOP_BITS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            ready_d = 1'b1;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.tx_ready = ready_q;
  assign tx           = tx_q;
  assign busy         = busy_q;
  assign timer_start  = start_q;
  assign timer_stop   = stop_q;
  assign frame_done   = done_q;
endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Directed bench: four sequencers (8N1, 8E1, 8O1, 8N2) driven side by side from one tick source.
module tb_uart_tx_sequencer;
  localparam bit [3:0] PE = 4'b0110;
  localparam bit [3:0] PO = 4'b0100;
  localparam bit [3:0] S2 = 4'b1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [7:0] data = '0;
  logic [3:0] valid_v = '0;
  logic [3:0] tx_v, ready_v, busy_v, ts_v, tp_v, fd_v;

  int n_chk = 0;
  int n_fail = 0;
  int ts_cnt[4] = '{default: 0};
  int tp_cnt[4] = '{default: 0};
  int ovl_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_tx_sequencer_if #(.DATA_BITS(8)) bus ();
    assign bus.tx_data  = data;
    assign bus.tx_valid = valid_v[g];
    assign ready_v[g]   = bus.tx_ready;
    uart_tx_sequencer #(
      .DATA_BITS (8),
      .PARITY_EN (PE[g]),
      .PARITY_ODD(PO[g]),
      .STOP_BITS (S2[g] ? 2 : 1)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .tick       (tick),
      .tx         (tx_v[g]),
      .busy       (busy_v[g]),
      .timer_start(ts_v[g]),
      .timer_stop (tp_v[g]),
      .frame_done (fd_v[g])
    );
  end

  // Pulses last one full cycle, so each is seen on exactly one falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      ts_cnt[i] <= ts_cnt[i] + int'(ts_v[i]);
      tp_cnt[i] <= tp_cnt[i] + int'(tp_v[i]);
    end
    if (|(ts_v & tp_v)) ovl_cnt <= ovl_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int flen(input int i);
    return 10 + int'(PE[i]) + int'(S2[i]);
  endfunction

  // Line level after k ticks: k=0 start bit, 1..8 data LSB first, then parity/stop.
  function automatic logic exp_tx(input int i, input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9 && PE[i]) return (^d) ^ PO[i];
    return 1'b1;
  endfunction

  task automatic acc(input logic [7:0] d, input logic [3:0] m, input bit ovl, input bit keep);
    @(negedge clk);
    data = d; valid_v = m; tick = ovl;
    @(negedge clk);
    if (!keep) valid_v = '0;
    tick = 1'b0;
    for (int i = 0; i < 4; i++) if (m[i]) begin
      chk($sformatf("acc_tx%0d", i), tx_v[i], 1'b0);
      chk($sformatf("acc_ready%0d", i), ready_v[i], 1'b0);
      chk($sformatf("acc_busy%0d", i), busy_v[i], 1'b1);
      chk($sformatf("acc_tstart%0d", i), ts_v[i], 1'b1);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (m[i]) begin
      chk($sformatf("tstart_fall%0d", i), ts_v[i], 1'b0);
      chk($sformatf("start_hold%0d", i), tx_v[i], 1'b0);
    end
    if (ovl) begin
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) if (m[i])
        chk($sformatf("ovl_start%0d", i), tx_v[i], 1'b0);
    end
  endtask

  task automatic ticks(input logic [7:0] d, input logic [3:0] m, input int n);
    for (int k = 1; k <= n; k++) begin
      repeat (15) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      for (int i = 0; i < 4; i++) if (m[i]) begin
        chk($sformatf("tx%0d_k%0d", i, k), tx_v[i], exp_tx(i, d, k));
        chk($sformatf("done%0d_k%0d", i, k), fd_v[i], k == flen(i));
        chk($sformatf("tstop%0d_k%0d", i, k), tp_v[i], k == flen(i));
        chk($sformatf("busy%0d_k%0d", i, k), busy_v[i], k < flen(i));
        chk($sformatf("ready%0d_k%0d", i, k), ready_v[i], k >= flen(i));
      end
    end
  endtask

  task automatic frame(input logic [7:0] d, input logic [3:0] m, input bit ovl);
    int s[4];
    int p[4];
    for (int i = 0; i < 4; i++) begin s[i] = ts_cnt[i]; p[i] = tp_cnt[i]; end
    acc(d, m, ovl, 1'b0);
    ticks(d, m, 12);
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (m[i]) begin
      chk($sformatf("nstart%0d", i), ts_cnt[i] - s[i], 1);
      chk($sformatf("nstop%0d", i), tp_cnt[i] - p[i], 1);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx"}, tx_v, 4'hF);
    chk({tag, "_ready"}, ready_v, 4'hF);
    chk({tag, "_busy"}, busy_v, 4'h0);
    chk({tag, "_tstart"}, ts_v, 4'h0);
    chk({tag, "_tstop"}, tp_v, 4'h0);
    chk({tag, "_done"}, fd_v, 4'h0);
  endtask

  initial begin
    int s0, p0, ov0;
    #1 rst = 1'b1;
    #2 chk_reset_vals("rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("post_rst");

    // Ticks in IDLE: no line change and no timer pulses
    s0 = ts_cnt[0] + ts_cnt[3]; p0 = tp_cnt[0] + tp_cnt[3];
    repeat (3) begin
      tick = 1'b1; @(negedge clk); tick = 1'b0;
      chk("idle_tx", tx_v, 4'hF);
      chk("idle_ready", ready_v, 4'hF);
      @(negedge clk);
    end
    chk("idle_nstart", ts_cnt[0] + ts_cnt[3] - s0, 0);
    chk("idle_nstop", tp_cnt[0] + tp_cnt[3] - p0, 0);

    frame(8'hA5, 4'hF, 1'b0);
    frame(8'h03, 4'hF, 1'b0);
    frame(8'hFF, 4'hF, 1'b0);
    frame(8'h96, 4'hF, 1'b1);

    // Back-to-back on the 8N1 unit with tx_valid held
    s0 = ts_cnt[0]; p0 = tp_cnt[0]; ov0 = ovl_cnt;
    acc(8'h55, 4'b0001, 1'b0, 1'b1);
    ticks(8'h55, 4'b0001, 10);
    chk("b2b_end_tstart", ts_v[0], 1'b0);
    data = 8'h0F;
    @(negedge clk);
    chk("b2b_acc_ready", ready_v[0], 1'b0);
    chk("b2b_acc_tstart", ts_v[0], 1'b1);
    chk("b2b_acc_tstop", tp_v[0], 1'b0);
    chk("b2b_acc_tx", tx_v[0], 1'b0);
    valid_v = '0;
    ticks(8'h0F, 4'b0001, 12);
    @(negedge clk);
    chk("b2b_nstart", ts_cnt[0] - s0, 2);
    chk("b2b_nstop", tp_cnt[0] - p0, 2);
    chk("b2b_overlap", ovl_cnt - ov0, 0);

    // Reset during data bit 3
    acc(8'hA5, 4'hF, 1'b0, 1'b0);
    ticks(8'hA5, 4'hF, 4);
    p0 = tp_cnt[0] + tp_cnt[1] + tp_cnt[2] + tp_cnt[3];
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_nstop", tp_cnt[0] + tp_cnt[1] + tp_cnt[2] + tp_cnt[3] - p0, 0);
    frame(8'h3C, 4'hF, 1'b0);

    chk("overlap_total", ovl_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
